mem_arbiter: RTL and testbench

- Shares the single four-banked main memory between the D-cache controller (port 0) and the I-cache controller (port 1).
- Arbitrates each access round-robin and honours per-port burst locks.
- Suppresses issue to busy banks.
- Routes returning read data to the issuing port through a tag pipeline matched to the memory read latency.
- Sits between both cache controllers and the memory macro.

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, lock-aware arbiter sharing one banked memory between D-cache (port 0) and I-cache (port 1).
// Define MEM_ARB_TIMEOUT_EN to bound how long a locked owner can starve the other port (MAX_HOLD cycles).
module mem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              stall0,
   output logic              stall1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [3:0]        busy,
   input  logic              mem_stall
);
   logic              r_last_gnt, r_locked, r_owner;
   logic [RD_LAT-1:0] r_vld, r_id;
   logic              w_req_o, w_lock_o, w_lk, w_g0, w_g1, w_wr, w_lock_g;
   logic              w_blk, w_acc, w_rd, w_to;
   logic [ADDR_W-1:0] w_addr;

   // a held lock only survives while its owner keeps both req and lock high
   assign w_req_o  = r_owner ? req1 : req0;
   assign w_lock_o = r_owner ? lock1 : lock0;
   assign w_lk     = r_locked & w_req_o & w_lock_o;
   assign w_g0     = w_lk ? ~r_owner : req0 & (~req1 | r_last_gnt);
   assign w_g1     = w_lk ? r_owner : req1 & (~req0 | ~r_last_gnt);

   assign w_addr   = w_g1 ? addr1 : addr0;
   assign w_wr     = w_g1 ? wr1 : wr0;
   assign w_lock_g = w_g1 ? lock1 : lock0;
   assign w_blk    = mem_stall | busy[w_addr[2:1]];
   assign w_acc    = (w_g0 | w_g1) & ~w_blk;
   assign w_rd     = w_acc & ~w_wr;

   // reset forces every combinational output low without waiting for a clock
   assign gnt0      = rst & w_g0;
   assign gnt1      = rst & w_g1;
   assign stall0    = gnt0 & w_blk;
   assign stall1    = gnt1 & w_blk;
   assign mem_rd    = rst & w_rd;
   assign mem_wr    = rst & w_acc & w_wr;
   assign mem_addr  = rst ? w_addr : '0;
   assign mem_wdata = rst ? (w_g1 ? wdata1 : wdata0) : '0;
   assign rvalid0   = r_vld[RD_LAT-1] & ~r_id[RD_LAT-1];
   assign rvalid1   = r_vld[RD_LAT-1] & r_id[RD_LAT-1];
   assign rdata     = r_vld[RD_LAT-1] ? mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] r_hold;
   logic          w_wait;
   assign w_wait = w_lk & (r_owner ? req0 : req1);
   assign w_to   = w_wait & (r_hold == HW'(MAX_HOLD - 1));
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_hold <= '0;
      else      r_hold <= (w_wait & ~w_to) ? r_hold + 1'b1 : '0;
`else
   assign w_to = (MAX_HOLD < 0);
`endif

   // on timeout the owner is recorded as last winner so the starved port takes the next tie
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_last_gnt <= 1'b1;
         r_locked   <= 1'b0;
         r_owner    <= 1'b0;
         r_vld      <= '0;
         r_id       <= '0;
      end else begin
         r_vld      <= (r_vld << 1) | RD_LAT'(w_rd);
         r_id       <= (r_id << 1) | RD_LAT'(w_g1);
         r_last_gnt <= w_to ? r_owner : (w_acc ? w_g1 : r_last_gnt);
         r_locked   <= ~w_to & ((w_acc & w_lock_g) | w_lk);
         r_owner    <= (w_acc & w_lock_g) ? w_g1 : r_owner;
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
   localparam int ADDR_W = 16, DATA_W = 16, RD_LAT = 2, MAX_HOLD = 16;
   logic        clk = 1'b0;
   logic        rst, req0, req1, wr0, wr1, lock0, lock1, mem_stall;
   logic [15:0] addr0, addr1, wdata0, wdata1, mem_rdata;
   logic [3:0]  busy;
   logic        gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, mem_rd, mem_wr;
   logic [15:0] rdata, mem_addr, mem_wdata;
   logic [15:0] m_a0, m_a1;
   logic [16:0] sb[$];
   int          n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
      .stall0(stall0), .stall1(stall1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
      .busy(busy), .mem_stall(mem_stall));

   function automatic logic [15:0] f(input logic [15:0] a);
      return (a == 16'h0004) ? 16'hBEEF : a ^ 16'h5A5A;
   endfunction

   // memory returns the word for the address presented RD_LAT cycles earlier
   always @(posedge clk) begin
      m_a0 <= mem_addr;
      m_a1 <= m_a0;
   end
   assign mem_rdata = f(m_a1);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [16:0] e;
      chk("gnt_excl", gnt0 & gnt1, 0);
      if (rvalid0 | rvalid1) begin
         if (sb.size() == 0) chk("sb_extra", {rvalid1, rvalid0}, 0);
         else begin
            e = sb.pop_front();
            chk("rv_port", {rvalid1, rvalid0}, e[16] ? 2 : 1);
            chk("rdata", rdata, e[15:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 0; req0 = 1; req1 = 0; wr0 = 0; wr1 = 0; lock0 = 0; lock1 = 0; mem_stall = 0;
      addr0 = 16'h1234; addr1 = 0; wdata0 = 16'h5678; wdata1 = 0; busy = 0;
      #3;
      chk("rst_ctl", {gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, mem_rd, mem_wr}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      step(); step();
      rst = 1; req0 = 0;
      // single port-0 read, data back RD_LAT cycles later
      req0 = 1; addr0 = 16'h0004; sb.push_back({1'b0, f(16'h0004)});
      @(negedge clk);
      chk("t1_gnt0", gnt0, 1); chk("t1_rd", mem_rd, 1); chk("t1_addr", mem_addr, 16'h0004);
      step(); req0 = 0;
      @(negedge clk); chk("t1_rv_early", rvalid0, 0);
      step();
      @(negedge clk); chk("t1_rv0", rvalid0, 1); chk("t1_rdata", rdata, 16'hBEEF); chk("t1_rv1", rvalid1, 0);
      repeat (3) step();
      req1 = 1; wr1 = 1; addr1 = 16'h0008; wdata1 = 16'h1111;
      @(negedge clk);
      chk("w1_gnt1", gnt1, 1); chk("w1_wr", mem_wr, 1); chk("w1_addr", mem_addr, 16'h0008); chk("w1_wdata", mem_wdata, 16'h1111);
      step(); req1 = 0; wr1 = 0;
      // round-robin alternation
      req0 = 1; req1 = 1; addr0 = 16'h0010; addr1 = 16'h0022;
      for (int i = 0; i < 6; i++) begin
         sb.push_back({i[0], f(i[0] ? 16'h0022 : 16'h0010)});
         @(negedge clk);
         chk("rr_gnt0", gnt0, !i[0]); chk("rr_gnt1", gnt1, i[0]);
         step();
      end
      req0 = 0; req1 = 0;
      repeat (4) step();
      // port-1 locked burst against a waiting port 0
      for (int i = 0; i < 5; i++) begin
         req1 = (i < 4); lock1 = (i < 4); addr1 = 16'h0030 + 16'(i);
         req0 = (i > 0); addr0 = 16'h0040;
         sb.push_back((i < 4) ? {1'b1, f(16'h0030 + 16'(i))} : {1'b0, f(16'h0040)});
         @(negedge clk);
         chk("lk_gnt1", gnt1, i < 4); chk("lk_gnt0", gnt0, i == 4);
         step();
      end
      req0 = 0; req1 = 0; lock1 = 0;
      repeat (6) step();
      // busy bank holds off a write
      busy = 4'b0100; req0 = 1; wr0 = 1; addr0 = 16'h0004; wdata0 = 16'hCAFE;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) busy = 4'b0000;
         @(negedge clk);
         chk("bz_stall0", stall0, i < 3); chk("bz_wr", mem_wr, i == 3);
         if (i == 3) chk("bz_wdata", mem_wdata, 16'hCAFE);
         step();
      end
      req0 = 0; wr0 = 0;
      @(negedge clk); chk("bz_wr_done", mem_wr, 0);
      step();
      req1 = 1; addr1 = 16'h0050; mem_stall = 1;
      @(negedge clk); chk("ms_stall1", stall1, 1); chk("ms_rd", mem_rd, 0);
      step(); mem_stall = 0; sb.push_back({1'b1, f(16'h0050)});
      @(negedge clk); chk("ms_stall1_off", stall1, 0); chk("ms_rd_on", mem_rd, 1);
      step(); req1 = 0;
      repeat (4) step();
      // lock held by port 0 while port 1 waits
      for (int i = 0; i < 20; i++) begin
         req0 = 1; wr0 = 1; lock0 = 1; addr0 = 16'h0060;
         req1 = (i > 0); wr1 = 1; addr1 = 16'h0068;
         @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
         if (i <= MAX_HOLD + 1) begin
            chk("to_gnt0", gnt0, i <= MAX_HOLD); chk("to_gnt1", gnt1, i == MAX_HOLD + 1);
         end
`else
         chk("hold_gnt0", gnt0, 1); chk("hold_gnt1", gnt1, 0);
`endif
         step();
      end
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; lock0 = 0;
      repeat (3) step();
      // reset lands while a read is in flight
      req0 = 1; addr0 = 16'h0070;
      @(negedge clk); chk("t6_rd", mem_rd, 1);
      step();
      rst = 0; req0 = 0; req1 = 1; addr1 = 16'h0074; wdata1 = 16'h9999;
      #1;
      chk("t6_ctl", {gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, mem_rd, mem_wr}, 0);
      chk("t6_addr", mem_addr, 0);
      chk("t6_wdata", mem_wdata, 0);
      step();
      rst = 1; req1 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("t6_rv0", rvalid0, 0); chk("t6_rv1", rvalid1, 0);
         step();
      end
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
